arbitro_memoria: RTL and testbench

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria_if.sv | 55 +++++
 rtl/arbitro_memoria.sv | 144 ++++++++++++++
 tb/tb_arbitro_memoria.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_if
//   Bundles every bus signal around the memory arbiter: the two requester
//   ports, the completion/status outputs and the data-memory side.
//
//   modport slave  : the arbiter itself (samples requests and mem_rdata,
//                    drives acks, status and the memory strobes).
//   modport master : everything surrounding the arbiter (requesters and the
//                    attached data memory).
//
//   Signals
//     req0/req1      request from port 0 (CPU) / port 1 (loader/debug)
//     we0/we1        1 = write, 0 = read
//     addr0/addr1    word address
//     wdata0/wdata1  write data
//     ack0/ack1      one-cycle completion pulse to the granted port
//     rdata          read data, valid only with an ack
//     err            completed access was out of range
//     busy           arbiter is not idle
//     mem_addr       address to data memory
//     mem_wdata      write data to data memory
//     mem_write      memory write strobe
//     mem_read       memory read strobe
//     mem_rdata      combinational read data from data memory
// -----------------------------------------------------------------------------
interface arbitro_memoria_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, err, busy, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, err, busy, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
//   Two-port arbiter in front of a single-ported data memory of DEPTH 32-bit
//   words. Each access takes three cycles: IDLE (arbitrate and latch the
//   winner), ACCESS (one memory strobe), DONE (ack pulse with rdata/err).
//   All outputs, memory side included, come straight from registers.
//
//   Parameters
//     DEPTH   number of words in the attached memory; addr >= DEPTH is out
//             of range (no strobe, err=1, rdata=0)
//
//   Ports
//     clk     single clock, rising edge
//     reset   synchronous, active-high; aborts any access in flight
//     bus     arbitro_memoria_if.slave (requesters + memory side)
//
//   Configuration
//     ARBITRO_ROUND_ROBIN_EN  defined: simultaneous requests alternate between
//                             the ports; undefined: port 0 has fixed priority.
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int unsigned DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    arbitro_memoria_if.slave   bus
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;

    // Latched description of the access in flight.
    logic        lat_port;
    logic        lat_we;
    logic        lat_oor;

`ifdef ARBITRO_ROUND_ROBIN_EN
    // Port preferred on the next simultaneous request.
    logic        rr_ptr;
`endif

    // Winner selection (only consumed in IDLE).
    logic        sel_port;
    logic        sel_we;
    logic        sel_oor;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sel_port = 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
        if (bus.req0 && bus.req1) begin
            sel_port = rr_ptr;
        end else begin
            sel_port = !bus.req0;
        end
`else
        sel_port = !bus.req0;
`endif
        sel_we    = sel_port ? bus.we1    : bus.we0;
        sel_addr  = sel_port ? bus.addr1  : bus.addr0;
        sel_wdata = sel_port ? bus.wdata1 : bus.wdata0;
        sel_oor   = (sel_addr >= DEPTH_W);
    end

    // NOTE: state and outputs are registers, so this block uses non-blocking
    // assignments only; blocking ones would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_port      <= 1'b0;
            lat_we        <= 1'b0;
            lat_oor       <= 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
            rr_ptr        <= 1'b0;
`endif
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.rdata     <= '0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state         <= ACCESS;
                        bus.busy      <= 1'b1;
                        lat_port      <= sel_port;
                        lat_we        <= sel_we;
                        lat_oor       <= sel_oor;
                        // mem_addr/mem_wdata double as the latched address/data.
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_write <= sel_we  && !sel_oor;
                        bus.mem_read  <= !sel_we && !sel_oor;
`ifdef ARBITRO_ROUND_ROBIN_EN
                        rr_ptr        <= !sel_port;
`endif
                    end
                end

                ACCESS: begin
                    state         <= DONE;
                    bus.mem_write <= 1'b0;
                    bus.mem_read  <= 1'b0;
                    bus.ack0      <= !lat_port;
                    bus.ack1      <= lat_port;
                    bus.err       <= lat_oor;
                    // Memory read data is combinational; capture it as the
                    // read strobe ends.
                    bus.rdata     <= (!lat_we && !lat_oor) ? bus.mem_rdata : '0;
                end

                DONE: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.ack0      <= 1'b0;
                    bus.ack1      <= 1'b0;
                    bus.err       <= 1'b0;
                    bus.rdata     <= '0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria
//   Self-checking bench for arbitro_memoria. A transaction-level reference
//   model (pending access + age since grant, plus a word array for memory
//   contents) predicts every output each cycle. Directed scenarios cover the
//   write/read round trip, out-of-range access, reset abort and arbitration;
//   a randomized phase follows. Build with +define+ARBITRO_ROUND_ROBIN_EN to
//   check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam int          DEPTH   = 32;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arbitro_memoria_if bus ();

    arbitro_memoria #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Attached data memory: combinational read, write at the clock edge.
    logic [31:0] tb_mem [DEPTH] = '{default: 32'h0};

    assign bus.mem_rdata = (bus.mem_addr < DEPTH_W) ? tb_mem[bus.mem_addr[4:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (bus.mem_write) tb_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end

    // ---------------------------------------------------------------- checking
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // One access at a time: granted when idle and someone requests, then one
    // cycle of memory strobe (age 0) and one cycle of ack (age 1).
    bit          m_active = 1'b0;
    int          m_age    = 0;
    int          m_port   = 0;
    bit          m_we     = 1'b0;
    bit          m_inr    = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rdata  = '0;
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
`ifdef ARBITRO_ROUND_ROBIN_EN
    int          m_pref   = 0;
`endif

    function automatic int pick_port();
`ifdef ARBITRO_ROUND_ROBIN_EN
        if (bus.req0 && bus.req1) return m_pref;
`endif
        return bus.req0 ? 0 : 1;
    endfunction

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_update();
        if (reset) begin
            m_active = 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
            m_pref   = 0;
`endif
        end else if (!m_active) begin
            if (bus.req0 || bus.req1) begin
                m_port  = pick_port();
                m_we    = (m_port == 1) ? bus.we1    : bus.we0;
                m_addr  = (m_port == 1) ? bus.addr1  : bus.addr0;
                m_wdata = (m_port == 1) ? bus.wdata1 : bus.wdata0;
                m_inr   = (m_addr < DEPTH_W);
                m_rdata = '0;
                if (m_inr) begin
                    // A granted strobe always runs a full cycle, so the
                    // memory sees the write even if reset aborts the ack.
                    if (m_we) ref_mem[m_addr[4:0]] = m_wdata;
                    else      m_rdata = ref_mem[m_addr[4:0]];
                end
                m_active = 1'b1;
                m_age    = 0;
`ifdef ARBITRO_ROUND_ROBIN_EN
                m_pref   = 1 - m_port;
`endif
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            m_active = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit acc;
        bit don;
        acc = m_active && (m_age == 0);
        don = m_active && (m_age == 1);
        check("busy",      32'(bus.busy),      32'(m_active));
        check("mem_write", 32'(bus.mem_write), 32'(acc && m_we && m_inr));
        check("mem_read",  32'(bus.mem_read),  32'(acc && !m_we && m_inr));
        check("mem_addr",  bus.mem_addr,       m_active ? m_addr  : 32'h0);
        check("mem_wdata", bus.mem_wdata,      m_active ? m_wdata : 32'h0);
        check("ack0",      32'(bus.ack0),      32'(don && (m_port == 0)));
        check("ack1",      32'(bus.ack1),      32'(don && (m_port == 1)));
        check("err",       32'(bus.err),       32'(don && !m_inr));
        check("rdata",     bus.rdata,          don ? m_rdata : 32'h0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------------------------------------------------------- stimulus
    task automatic drive(input int port, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic new_req(input int port);
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = DEPTH_W;
            1:       a = DEPTH_W + 32'($urandom_range(1, 100));
            2:       a = 32'hFFFF_FFFF;
            default: a = 32'($urandom_range(0, DEPTH - 1));
        endcase
        drive(port, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    // Single access on one port, holding req until its ack (bounded).
    task automatic do_access(input int port, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output bit got_ack,
                             output int lat, output logic [31:0] got_rdata,
                             output bit got_err);
        got_ack   = 1'b0;
        lat       = 0;
        got_rdata = '0;
        got_err   = 1'b0;
        drive(port, 1'b1, w, a, d);
        for (int i = 0; i < 8 && !got_ack; i++) begin
            tick();
            if ((port == 0) ? bus.ack0 : bus.ack1) begin
                got_ack   = 1'b1;
                lat       = i + 1;
                got_rdata = bus.rdata;
                got_err   = bus.err;
            end
        end
        drive(port, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        bit          ack;
        int          lat;
        logic [31:0] rd;
        bit          er;
        int          acks_seen;
        int          grants [4];
        int          n_grants;
        int          exp_g [4];

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Port 0 write then read back at address 5.
        do_access(0, 1'b1, 32'd5, 32'hDEAD_BEEF, ack, lat, rd, er);
        check("wr5_ack", 32'(ack), 32'd1);
        check("wr5_lat", 32'(lat), 32'd2);
        do_access(0, 1'b0, 32'd5, '0, ack, lat, rd, er);
        check("rd5_ack",   32'(ack), 32'd1);
        check("rd5_rdata", rd, 32'hDEAD_BEEF);
        check("rd5_err",   32'(er), 32'd0);

        // Out-of-range read on port 1, then an in-range one.
        do_access(1, 1'b0, DEPTH_W, '0, ack, lat, rd, er);
        check("oor_ack",   32'(ack), 32'd1);
        check("oor_err",   32'(er), 32'd1);
        check("oor_rdata", rd, 32'h0);
        do_access(1, 1'b0, 32'd5, '0, ack, lat, rd, er);
        check("inr_err",   32'(er), 32'd0);
        check("inr_rdata", rd, 32'hDEAD_BEEF);

        // Reset during the ACCESS cycle of a write aborts it.
        drive(0, 1'b1, 1'b1, 32'd9, 32'h1234_5678);
        tick();
        check("abort_strobe", 32'(bus.mem_write), 32'd1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        reset = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ack0) acks_seen++;
        end
        check("abort_no_ack", 32'(acks_seen), 32'd0);

        // Loader write 7 at the top address, then read it back on port 1.
        do_access(1, 1'b1, 32'd31, 32'h0000_0007, ack, lat, rd, er);
        check("wr31_ack", 32'(ack), 32'd1);
        do_access(1, 1'b0, 32'd31, '0, ack, lat, rd, er);
        check("rd31_rdata", rd, 32'h0000_0007);
        check("rd31_err",   32'(er), 32'd0);

        // Both ports reading, held: grant sequence after a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'd1, '0);
        drive(1, 1'b1, 1'b0, 32'd2, '0);
        n_grants = 0;
        grants   = '{-1, -1, -1, -1};
        for (int i = 0; i < 16 && n_grants < 4; i++) begin
            tick();
            if (bus.ack0 || bus.ack1) begin
                grants[n_grants] = bus.ack1 ? 1 : 0;
                n_grants++;
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
`ifdef ARBITRO_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        check("arb_count", 32'(n_grants), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
        end

        // Randomized traffic: requesters follow the held-until-ack protocol,
        // with occasional early drops, back-to-back requests and resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                bit acked;
                bit cur;
                acked = m_active && (m_age == 1) && (m_port == p);
                cur   = (p == 0) ? bus.req0 : bus.req1;
                if (cur) begin
                    if (acked) begin
                        if ($urandom_range(0, 3) == 0) new_req(p);
                        else drive(p, 1'b0, 1'b0, '0, '0);
                    end else if ($urandom_range(0, 63) == 0) begin
                        drive(p, 1'b0, 1'b0, '0, '0);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
            tick();
        end

        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
